// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_RD_DEF = 2;

  // Addresses are zero-extended to this width before comparison.
  localparam int unsigned ADDR_W_MAX = 16;

  typedef logic [ADDR_W_MAX-1:0] rf_addr_t;

  // Write-address match: the write port is active and targets the read address.
  function automatic logic rf_match(input logic en, input rf_addr_t wn, input rf_addr_t rn);
    return en && (wn == rn);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, two write ports, issue.
interface reg_file_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);

  logic [NUM_RD*ADDR_W-1:0] Rn;
  logic [NUM_RD*DATA_W-1:0] A;
  logic [NUM_RD-1:0]        Busy;

  logic                     Write0;
  logic [ADDR_W-1:0]        Wn0;
  logic [DATA_W-1:0]        Wd0;

  logic                     Write1;
  logic [ADDR_W-1:0]        Wn1;
  logic [DATA_W-1:0]        Wd1;

  logic                     Issue;
  logic [ADDR_W-1:0]        IssueWn;

  // Datapath side: presents addresses, writes and issues; consumes read data.
  modport master (
    output Rn, Write0, Wn0, Wd0, Write1, Wn1, Wd1, Issue, IssueWn,
    input  A, Busy
  );

  // Register file side.
  modport slave (
    input  Rn, Write0, Wn0, Wd0, Write1, Wn1, Wd1, Issue, IssueWn,
    output A, Busy
  );

endinterface

// File: rtl/reg_file_mp_rf_read_port.sv
// One read port: storage mux, write forwarding, zero-register mask, busy qualify.
module rf_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          RD_REG   = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ADDR_W-1:0]                   rn_i,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  mem_i,
  input  logic [(2**ADDR_W)-1:0]              busy_vec_i,
  input  logic                                wr0_en_i,
  input  logic [ADDR_W-1:0]                   wr0_addr_i,
  input  logic [DATA_W-1:0]                   wr0_data_i,
  input  logic                                wr1_en_i,
  input  logic [ADDR_W-1:0]                   wr1_addr_i,
  input  logic [DATA_W-1:0]                   wr1_data_i,
  output logic [DATA_W-1:0]                   rd_data_c_o,
  output logic                                busy_c_o
);

  logic              m0;
  logic              m1;
  logic              is_zero;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] fwd;
  logic [DATA_W-1:0] comb_val;
  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

  // Read mux with port-1-over-port-0 forwarding; register 0 masked to zero.
  always_comb begin
    raw      = mem_i[rn_i];
    m0       = rf_match(wr0_en_i, ADDR_W_MAX'(wr0_addr_i), ADDR_W_MAX'(rn_i));
    m1       = rf_match(wr1_en_i, ADDR_W_MAX'(wr1_addr_i), ADDR_W_MAX'(rn_i));
    is_zero  = ZERO_REG && (rn_i == '0);
    fwd      = raw;
    if (m0) fwd = wr0_data_i;
    if (m1) fwd = wr1_data_i;
    // Registered capture is always write-first so it matches post-edge storage.
    rd_d     = is_zero ? '0 : fwd;
    comb_val = is_zero ? '0 : (BYPASS ? fwd : raw);
    busy_c_o = busy_vec_i[rn_i] & ~(BYPASS & (m0 | m1)) & ~is_zero;
  end

  // Optional output register for the one-cycle-latency read mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data_c_o = RD_REG ? rd_q : comb_val;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: storage, busy scoreboard and NUM_RD read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          RD_REG   = 1'b0
) (
  input  logic          Clock,
  input  logic          Resetn,
  reg_file_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] mem_d;
  logic [DEPTH-1:0]             busy_q;
  logic [DEPTH-1:0]             busy_d;
  logic                         wr0_ok;
  logic                         wr1_ok;
  logic                         iss_ok;

  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]             rd_busy;

  // Next storage contents: port 1 applied last so it wins on an address clash.
  always_comb begin
    wr0_ok = bus.Write0 && !(ZERO_REG && (bus.Wn0 == '0));
    wr1_ok = bus.Write1 && !(ZERO_REG && (bus.Wn1 == '0));
    mem_d  = mem_q;
    if (wr0_ok) mem_d[bus.Wn0] = bus.Wd0;
    if (wr1_ok) mem_d[bus.Wn1] = bus.Wd1;
  end

  // Next scoreboard: writes retire a pending producer, a new issue overrides.
  always_comb begin
    iss_ok = bus.Issue && !(ZERO_REG && (bus.IssueWn == '0));
    busy_d = busy_q;
    if (bus.Write0) busy_d[bus.Wn0] = 1'b0;
    if (bus.Write1) busy_d[bus.Wn1] = 1'b0;
    if (iss_ok)     busy_d[bus.IssueWn] = 1'b1;
  end

  // Storage and scoreboard state, cleared asynchronously.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .RD_REG   (RD_REG)
    ) u_port (
      .clk         (Clock),
      .rst_n       (Resetn),
      .rn_i        (bus.Rn[g*ADDR_W +: ADDR_W]),
      .mem_i       (mem_q),
      .busy_vec_i  (busy_q),
      .wr0_en_i    (bus.Write0),
      .wr0_addr_i  (bus.Wn0),
      .wr0_data_i  (bus.Wd0),
      .wr1_en_i    (bus.Write1),
      .wr1_addr_i  (bus.Wn1),
      .wr1_data_i  (bus.Wd1),
      .rd_data_c_o (rd_data[g]),
      .busy_c_o    (rd_busy[g])
    );
  end

  assign bus.A    = rd_data;
  assign bus.Busy = rd_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench: a combinational-read file and a registered-read 4-port file share stimulus.
module tb_reg_file_mp;

  localparam int unsigned DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus0 ();
  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4)) bus1 ();

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1),
                .BYPASS(1'b1), .RD_REG(1'b0))
    dut0 (.Clock(clk), .Resetn(rst_n), .bus(bus0));

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1'b1),
                .BYPASS(1'b1), .RD_REG(1'b1))
    dut1 (.Clock(clk), .Resetn(rst_n), .bus(bus1));

  typedef struct {
    logic [63:0]  a0;
    logic [1:0]   b0;
    logic [127:0] a1;
    logic [3:0]   b1;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: architectural registers, pending-producer flags, dut1 output latch.
  logic [31:0] mem_m [DEPTH];
  bit          busy_m [DEPTH];
  logic [31:0] a1_reg [4];

  // Current-cycle stimulus.
  logic        w0, w1, iss;
  logic [4:0]  wn0, wn1, iwn;
  logic [31:0] wd0, wd1;
  logic [4:0]  rn0 [2];
  logic [4:0]  rn1 [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value a reader sees this cycle: newest write wins, register 0 is always zero.
  function automatic logic [31:0] rd_exp(input logic [4:0] rn);
    if (rn == 5'd0) return '0;
    if (w1 && wn1 == rn) return wd1;
    if (w0 && wn0 == rn) return wd0;
    return mem_m[rn];
  endfunction

  function automatic logic busy_exp(input logic [4:0] rn);
    if (rn == 5'd0) return 1'b0;
    if ((w1 && wn1 == rn) || (w0 && wn0 == rn)) return 1'b0;
    return busy_m[rn];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      busy_m[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) a1_reg[i] = '0;
  endtask

  task automatic idle();
    w0 = 1'b0; w1 = 1'b0; iss = 1'b0;
    wn0 = '0; wn1 = '0; iwn = '0; wd0 = '0; wd1 = '0;
    for (int i = 0; i < 2; i++) rn0[i] = '0;
    for (int i = 0; i < 4; i++) rn1[i] = '0;
  endtask

  task automatic drive();
    bus0.Write0 = w0; bus0.Wn0 = wn0; bus0.Wd0 = wd0;
    bus0.Write1 = w1; bus0.Wn1 = wn1; bus0.Wd1 = wd1;
    bus0.Issue  = iss; bus0.IssueWn = iwn;
    bus0.Rn     = {rn0[1], rn0[0]};
    bus1.Write0 = w0; bus1.Wn0 = wn0; bus1.Wd0 = wd0;
    bus1.Write1 = w1; bus1.Wn1 = wn1; bus1.Wd1 = wd1;
    bus1.Issue  = iss; bus1.IssueWn = iwn;
    bus1.Rn     = {rn1[3], rn1[2], rn1[1], rn1[0]};
  endtask

  // Apply one cycle of stimulus, queue its expectation, advance the model past the edge.
  task automatic step();
    exp_t e;
    drive();
    for (int i = 0; i < 2; i++) begin
      e.a0[i*32 +: 32] = rd_exp(rn0[i]);
      e.b0[i]          = busy_exp(rn0[i]);
    end
    for (int i = 0; i < 4; i++) begin
      e.a1[i*32 +: 32] = a1_reg[i];
      e.b1[i]          = busy_exp(rn1[i]);
    end
    q.push_back(e);
    for (int i = 0; i < 4; i++) a1_reg[i] = rd_exp(rn1[i]);
    if (w0 && wn0 != 5'd0) mem_m[wn0] = wd0;
    if (w1 && wn1 != 5'd0) mem_m[wn1] = wd1;
    if (w0) busy_m[wn0] = 1'b0;
    if (w1) busy_m[wn1] = 1'b0;
    if (iss && iwn != 5'd0) busy_m[iwn] = 1'b1;
    @(posedge clk); #1;
  endtask

  // Assert reset between edges with data present; outputs must clear at once.
  task automatic reset_mid();
    idle();
    for (int i = 0; i < 2; i++) rn0[i] = 5'd1;
    for (int i = 0; i < 4; i++) rn1[i] = 5'(i + 1);
    drive();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_A0",    128'(bus0.A),    128'(0));
    check("rst_Busy0", 128'(bus0.Busy), 128'(0));
    check("rst_A1",    128'(bus1.A),    128'(0));
    check("rst_Busy1", 128'(bus1.Busy), 128'(0));
    @(posedge clk); #1;
    check("rst_hold_A1", 128'(bus1.A), 128'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rel_A1", 128'(bus1.A), 128'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("A_comb",    128'(bus0.A),    128'(e.a0));
        check("Busy_comb", 128'(bus0.Busy), 128'(e.b0));
        check("A_reg",     128'(bus1.A),    128'(e.a1));
        check("Busy_reg",  128'(bus1.Busy), 128'(e.b1));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    model_clear();
    idle();
    drive();
    #12;
    check("por_A1", 128'(bus1.A), 128'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("por_rel_A1", 128'(bus1.A), 128'(0));
    @(posedge clk); #1;

    // Bypass then stored read of r1.
    idle(); w0 = 1'b1; wn0 = 5'd1; wd0 = 32'd4; rn0[0] = 5'd1; rn1[0] = 5'd1; step();
    idle(); rn0[0] = 5'd1; rn1[0] = 5'd1; step();
    // Write-port priority on r2.
    idle(); w0 = 1'b1; wn0 = 5'd2; wd0 = 32'd5; w1 = 1'b1; wn1 = 5'd2; wd1 = 32'd9;
    rn0[1] = 5'd2; rn1[1] = 5'd2; step();
    idle(); rn0[1] = 5'd2; rn1[1] = 5'd2; step();
    // Zero register ignores writes and issues.
    idle(); w1 = 1'b1; wn1 = 5'd0; wd1 = 32'hDEADBEEF; iss = 1'b1; iwn = 5'd0; step();
    idle(); step();
    // Scoreboard on r3: issue, retire by write, issue+write collision.
    idle(); iss = 1'b1; iwn = 5'd3; rn0[0] = 5'd3; step();
    idle(); rn0[0] = 5'd3; rn1[2] = 5'd3; step();
    idle(); w0 = 1'b1; wn0 = 5'd3; wd0 = 32'd7; rn0[0] = 5'd3; rn1[2] = 5'd3; step();
    idle(); iss = 1'b1; iwn = 5'd3; step();
    idle(); iss = 1'b1; iwn = 5'd3; w1 = 1'b1; wn1 = 5'd3; wd1 = 32'd8; rn0[1] = 5'd3; step();
    idle(); rn0[0] = 5'd3; rn0[1] = 5'd3; rn1[2] = 5'd3; step();
    // Registered 4-port read with a same-cycle write to r4.
    idle(); w1 = 1'b1; wn1 = 5'd4; wd1 = 32'h55;
    for (int i = 0; i < 4; i++) rn1[i] = 5'(i + 1);
    step();
    idle(); for (int i = 0; i < 4; i++) rn1[i] = 5'(i + 1);
    step();

    reset_mid();

    for (int n = 0; n < 400; n++) begin
      w0  = 1'($urandom_range(0, 1));
      w1  = 1'($urandom_range(0, 1));
      iss = 1'($urandom_range(0, 1));
      wn0 = rand_addr(); wn1 = rand_addr(); iwn = rand_addr();
      wd0 = $urandom; wd1 = $urandom;
      for (int i = 0; i < 2; i++) rn0[i] = rand_addr();
      for (int i = 0; i < 4; i++) rn1[i] = rand_addr();
      step();
      if (n == 200) reset_mid();
    end

    idle(); step();
    @(negedge clk); #1;
    check("queue_drained", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the single-cycle/next-gen datapath.
- Generalises the 2-read/1-write 32x32 file to:
  - NUM_RD read ports.
  - Two write ports with fixed priority.
  - Optional hardwired zero register.
  - Same-cycle write-to-read bypass.
  - Optional registered-read mode.
  - Per-register busy scoreboard for pending writes.
- Sits between decode (read ports, issue) and writeback (write ports).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..8).
- ZERO_REG, 1, register 0 reads 0, ignores writes, never busy.
- BYPASS, 1, combinational forwarding of same-cycle write data to reads.
- RD_REG, 0:
  - 0: combinational read outputs.
  - 1: read outputs registered, 1-cycle latency.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- Rn  in  NUM_RD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- A  out  NUM_RD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W].
- Busy  out  NUM_RD  scoreboard busy flag of register addressed by port i.
- Write0  in  1  write enable, port 0.
- Wn0  in  ADDR_W  write address, port 0.
- Wd0  in  DATA_W  write data, port 0.
- Write1  in  1  write enable, port 1 (priority).
- Wn1  in  ADDR_W  write address, port 1.
- Wd1  in  DATA_W  write data, port 1.
- Issue  in  1  mark IssueWn as pending.
- IssueWn  in  ADDR_W  destination register being issued.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - All registers cleared to 0.
  - All busy bits cleared.
  - RD_REG=1: A registers cleared to 0.
  - RD_REG=0: A follows cleared contents, i.e. 0.
  - Reset takes effect immediately, independent of Clock.
  - Release is synchronous-safe: first active edge is the first Clock rise with Resetn=1.
- Write, on each posedge:
  - If WriteK=1, mem[WnK] <= WdK.
  - ZERO_REG=1: writes to address 0 are discarded.
  - Write0 and Write1 to the same address in the same cycle: port 1 data stored.
- Read, RD_REG=0:
  - A_i = mem[Rn_i] combinationally.
  - BYPASS=1: if Write1 && Wn1==Rn_i then A_i=Wd1; else if Write0 && Wn0==Rn_i then A_i=Wd0.
  - ZERO_REG=1 and Rn_i==0: A_i=0 regardless of bypass.
- Read, RD_REG=1:
  - A_i registered on posedge; latency 1.
  - Captured value is write-first: the bypassed value as above, whatever BYPASS is set to.
  - Identical to the value mem[Rn_i] holds after the edge.
- Scoreboard:
  - One busy bit per register.
  - Set on posedge when Issue=1, except when IssueWn==0 with ZERO_REG=1.
  - Cleared on posedge when any write port writes that address.
  - Issue and write to the same address in the same cycle: set wins (new producer supersedes).
- Busy output:
  - Busy_i = busy[Rn_i] & ~(BYPASS & (a write this cycle matches Rn_i)).
  - Forced 0 for address 0 when ZERO_REG=1.
  - Always combinational.
  - RD_REG=1: Busy_i is NOT delayed; it qualifies the address presented this cycle.
- Unused or out-of-range conditions: none; all 2**ADDR_W addresses are valid.
- No X propagation from uninitialised storage, since reset clears everything.

Decomposition:
- Package reg_file_pkg:
  - Default constants DATA_W_DEF=32, ADDR_W_DEF=5, NUM_RD_DEF=2.
  - Function rf_match(en, wn, rn) returning the write-address-match bit.
- Sub-module rf_read_port:
  - Contents: one read mux, bypass priority logic, zero-register masking, busy qualification, optional output register.
  - Instantiated NUM_RD times in a generate loop.
  - Storage and scoreboard stay in the top.

Test Plan:
- Reset then read, with Resetn=0 mid-simulation after registers hold data:
  - Write r1=4, then assert Resetn=0 between edges.
  - Required: A for Rn=1 reads 0 immediately; all Busy=0.
- Basic write/read (RD_REG=0, BYPASS=1):
  - Write0 r1=4 with Rn0=1 in the same cycle -> A0=4 before the edge (bypass).
  - After the edge, with Write0=0 -> A0=4.
- Write-port priority:
  - Write0 r2=5 and Write1 r2=9 in the same cycle -> A for Rn=2 is 9 same cycle and after the edge.
- Zero register:
  - Write1 r0=0xDEADBEEF and Issue r0 -> A for Rn=0 is 0; Busy=0 for Rn=0.
- Scoreboard:
  - Issue r3 -> Busy for Rn=3 is 1 next cycle.
  - Write0 r3=7 -> Busy=0 in that cycle (bypass) and A=7.
  - Issue r3 and Write r3 in the same cycle -> Busy stays 1 after the edge.
- Registered mode (RD_REG=1, NUM_RD=4):
  - Rn0..3 = 1,2,3,4 with Write1 r4=0x55.
  - Required: after the edge, A3=0x55 and A0..2 equal stored values; before the first edge after reset, all A=0.
